// File: rtl/subsystem_fetch_if.sv
// Fetch-stage bus bundle: PC input, instruction-memory read port and decode handoff.
interface subsystem_fetch_if;
    localparam int unsigned XLEN = 16;

    logic            stall;
    logic            flush;
    logic [XLEN-1:0] pc;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ack;
    logic            pc_enable;
    logic            fetch_fault;

    // Fetch unit side
    modport master (
        input  pc, stall, flush, mem_ready, mem_rdata, inst_ack,
        output mem_req, mem_addr, inst, inst_pc, inst_valid, pc_enable, fetch_fault
    );

    // Environment side: PC adder, instruction memory and decode
    modport slave (
        output pc, stall, flush, mem_ready, mem_rdata, inst_ack,
        input  mem_req, mem_addr, inst, inst_pc, inst_valid, pc_enable, fetch_fault
    );
endinterface

// File: rtl/subsystem_fetch.sv
// Instruction-fetch stage: samples pc, reads instruction memory, holds the word for decode,
// pulses pc_enable to advance the PC adder, and faults on a memory that never answers.
module subsystem_fetch #(
    parameter int unsigned MAX_WAIT = 255,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic             CLK,
    input  logic             reset,
    subsystem_fetch_if.master bus
);
    localparam int unsigned XLEN = 16;
    localparam int unsigned CW   = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            pc_enable_q, pc_enable_d;
    logic            fetch_fault_q, fetch_fault_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            inst_q        <= NOP_INST;
            inst_pc_q     <= '0;
            inst_valid_q  <= 1'b0;
            pc_enable_q   <= 1'b0;
            fetch_fault_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            pc_enable_q   <= pc_enable_d;
            fetch_fault_q <= fetch_fault_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state and next-output logic; flush outranks everything but FAULT
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;
        pc_enable_d   = 1'b0;
        fetch_fault_d = fetch_fault_q;
        cnt_d         = cnt_q;

        if (bus.flush && (state_q != FAULT)) begin
            state_d      = IDLE;
            mem_req_d    = 1'b0;
            inst_valid_d = 1'b0;
            cnt_d        = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.stall) begin
                        mem_addr_d = bus.pc;
                        mem_req_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        inst_d       = bus.mem_rdata;
                        inst_pc_d    = mem_addr_q;
                        inst_valid_d = 1'b1;
                        mem_req_d    = 1'b0;
                        pc_enable_d  = 1'b1;
                        state_d      = HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_d     = 1'b0;
                        fetch_fault_d = 1'b1;
                        state_d       = FAULT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (bus.inst_ack) begin
                        inst_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.inst        = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.pc_enable   = pc_enable_q;
    assign bus.fetch_fault = fetch_fault_q;
endmodule

// File: tb/tb_subsystem_fetch.sv
// Self-checking bench for subsystem_fetch: per-cycle vector table plus directed sequences.
module tb_subsystem_fetch;
    localparam logic [15:0] NOP = 16'hA5A5;

    logic CLK = 1'b0;
    logic r_reset = 1'b0;

    logic [15:0] r_pc = '0;
    logic        r_stall = 1'b0;
    logic        r_flush = 1'b0;
    logic        r_ready = 1'b0;
    logic [15:0] r_rdata = '0;
    logic        r_ack = 1'b0;
    logic        adder_mode = 1'b0;
    logic [15:0] pc_adder = '0;

    int checks = 0;
    int failures = 0;

    subsystem_fetch_if bus ();

    subsystem_fetch #(.MAX_WAIT(4), .NOP_INST(NOP)) dut (
        .CLK   (CLK),
        .reset (r_reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // PC adder model: advances by one on each pc_enable pulse
    always @(posedge CLK) begin
        if (!r_reset) pc_adder <= '0;
        else if (bus.pc_enable) pc_adder <= pc_adder + 16'd1;
    end

    // In adder mode: zero-wait memory returning addr^F0F0, decode always acks
    assign bus.pc        = adder_mode ? pc_adder : r_pc;
    assign bus.stall     = r_stall;
    assign bus.flush     = r_flush;
    assign bus.mem_ready = adder_mode ? 1'b1 : r_ready;
    assign bus.mem_rdata = adder_mode ? (bus.mem_addr ^ 16'hF0F0) : r_rdata;
    assign bus.inst_ack  = adder_mode ? 1'b1 : r_ack;

    typedef struct {
        logic        rst_n;
        logic [15:0] pc;
        logic        stall;
        logic        flush;
        logic        ready;
        logic [15:0] rdata;
        logic        ack;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_inst;
        logic [15:0] e_ipc;
        logic        e_v;
        logic        e_pe;
        logic        e_f;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic [15:0] pc, logic stall, logic flush,
                                logic ready, logic [15:0] rdata, logic ack,
                                logic e_req, logic [15:0] e_addr, logic [15:0] e_inst,
                                logic [15:0] e_ipc, logic e_v, logic e_pe, logic e_f);
        vec_t v;
        v.rst_n = rst_n; v.pc = pc; v.stall = stall; v.flush = flush;
        v.ready = ready; v.rdata = rdata; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_inst = e_inst; v.e_ipc = e_ipc;
        v.e_v = e_v; v.e_pe = e_pe; v.e_f = e_f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [15:0] e_addr,
                             input logic [15:0] e_inst, input logic [15:0] e_ipc,
                             input logic e_v, input logic e_pe, input logic e_f);
        chk({tag, ".mem_req"},     16'(bus.mem_req),     16'(e_req));
        chk({tag, ".mem_addr"},    bus.mem_addr,         e_addr);
        chk({tag, ".inst"},        bus.inst,             e_inst);
        chk({tag, ".inst_pc"},     bus.inst_pc,          e_ipc);
        chk({tag, ".inst_valid"},  16'(bus.inst_valid),  16'(e_v));
        chk({tag, ".pc_enable"},   16'(bus.pc_enable),   16'(e_pe));
        chk({tag, ".fetch_fault"}, 16'(bus.fetch_fault), 16'(e_f));
    endtask

    task automatic do_reset();
        r_reset = 1'b0;
        tick();
        r_reset = 1'b1;
    endtask

    initial begin
        // rst  pc      st fl rdy rdata    ack | req addr     inst     ipc      v  pe f
        vecs.push_back(mk(0, 16'h0010, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, NOP,      16'h0000, 0, 0, 0));
        // 2-wait fetch from 0x0010
        vecs.push_back(mk(1, 16'h0010, 0, 0, 0, 16'h0000, 0, 1, 16'h0010, NOP,      16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 0, 16'h0000, 0, 1, 16'h0010, NOP,      16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 0, 16'h0000, 0, 1, 16'h0010, NOP,      16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 1, 16'hABCD, 0, 0, 16'h0010, 16'hABCD, 16'h0010, 1, 1, 0));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 0, 16'h0000, 0, 0, 16'h0010, 16'hABCD, 16'h0010, 1, 0, 0));
        vecs.push_back(mk(1, 16'h0010, 1, 0, 0, 16'h0000, 1, 0, 16'h0010, 16'hABCD, 16'h0010, 0, 0, 0));
        // stall in IDLE for 5 cycles
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 16'h0020, 1, 0, 0, 16'h0000, 0, 0, 16'h0010, 16'hABCD, 16'h0010, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0020, 0, 0, 0, 16'h0000, 0, 1, 16'h0020, 16'hABCD, 16'h0010, 0, 0, 0));
        // flush coincident with mem_ready
        vecs.push_back(mk(1, 16'h0020, 1, 1, 1, 16'h1234, 0, 0, 16'h0020, 16'hABCD, 16'h0010, 0, 0, 0));
        // flush in HOLD coincident with inst_ack
        vecs.push_back(mk(1, 16'h0030, 0, 0, 0, 16'h0000, 0, 1, 16'h0030, 16'hABCD, 16'h0010, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0030, 1, 0, 1, 16'h5555, 0, 0, 16'h0030, 16'h5555, 16'h0030, 1, 1, 0));
        vecs.push_back(mk(1, 16'h0030, 1, 1, 1, 16'h9999, 1, 0, 16'h0030, 16'h5555, 16'h0030, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0030, 1, 0, 1, 16'h9999, 0, 0, 16'h0030, 16'h5555, 16'h0030, 0, 0, 0));

        #1;
        foreach (vecs[i]) begin
            r_reset = vecs[i].rst_n;
            r_pc    = vecs[i].pc;
            r_stall = vecs[i].stall;
            r_flush = vecs[i].flush;
            r_ready = vecs[i].ready;
            r_rdata = vecs[i].rdata;
            r_ack   = vecs[i].ack;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_inst,
                      vecs[i].e_ipc, vecs[i].e_v, vecs[i].e_pe, vecs[i].e_f);
        end
        r_stall = 1'b0; r_flush = 1'b0; r_ready = 1'b0; r_ack = 1'b0;

        // Back-to-back zero-wait fetches with the PC adder in the loop
        r_stall = 1'b1;
        adder_mode = 1'b1;
        do_reset();
        r_stall = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("b2b.pe.c%0d", c), 16'(bus.pc_enable),
                16'((c >= 2) && ((c - 2) % 3 == 0)));
            if ((c % 3) == 1) begin
                chk($sformatf("b2b.req.c%0d", c), 16'(bus.mem_req), 16'd1);
                chk($sformatf("b2b.addr.c%0d", c), bus.mem_addr, 16'((c - 1) / 3));
            end
            if (bus.pc_enable) begin
                chk($sformatf("b2b.ipc.c%0d", c), bus.inst_pc, 16'((c - 2) / 3));
                chk($sformatf("b2b.inst.c%0d", c), bus.inst, 16'((c - 2) / 3) ^ 16'hF0F0);
            end
        end
        r_stall = 1'b1;
        tick();
        adder_mode = 1'b0;

        // Timeout with MAX_WAIT=4, then flush must not leave FAULT
        r_pc = 16'h0040; r_ready = 1'b0;
        do_reset();
        r_stall = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("to.req.c%0d", c), 16'(bus.mem_req), 16'd1);
            chk($sformatf("to.fault.c%0d", c), 16'(bus.fetch_fault), 16'd0);
        end
        tick();
        chk("to.fault", 16'(bus.fetch_fault), 16'd1);
        chk("to.req_drop", 16'(bus.mem_req), 16'd0);
        r_flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("to.flush_fault.%0d", c), 16'(bus.fetch_fault), 16'd1);
            chk($sformatf("to.flush_req.%0d", c), 16'(bus.mem_req), 16'd0);
        end
        r_flush = 1'b0; r_ready = 1'b1; r_rdata = 16'hBEEF;
        tick();
        chk("to.late_ready_valid", 16'(bus.inst_valid), 16'd0);
        chk("to.late_ready_inst", bus.inst, NOP);
        chk("to.late_ready_fault", 16'(bus.fetch_fault), 16'd1);
        r_ready = 1'b0; r_stall = 1'b1;
        do_reset();
        chk("to.reset_clears", 16'(bus.fetch_fault), 16'd0);

        // Long HOLD without ack, then reset
        r_pc = 16'h0050; r_ready = 1'b1; r_rdata = 16'h7777; r_ack = 1'b0; r_stall = 1'b0;
        tick();
        tick();
        chk("hold.inst", bus.inst, 16'h7777);
        chk("hold.pe", 16'(bus.pc_enable), 16'd1);
        r_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold.stable.%0d", c), bus.inst, 16'h7777);
            chk($sformatf("hold.ipc.%0d", c), bus.inst_pc, 16'h0050);
            chk($sformatf("hold.valid.%0d", c), 16'(bus.inst_valid), 16'd1);
            chk($sformatf("hold.pe.%0d", c), 16'(bus.pc_enable), 16'd0);
        end
        r_reset = 1'b0;
        tick();
        chk("hold.rst_inst", bus.inst, NOP);
        chk("hold.rst_valid", 16'(bus.inst_valid), 16'd0);
        chk("hold.rst_ipc", bus.inst_pc, 16'h0000);
        r_reset = 1'b1;

        // Reset mid-REQ drops mem_req on that edge
        r_pc = 16'h0060; r_ready = 1'b0; r_stall = 1'b0;
        tick();
        chk("midreq.req", 16'(bus.mem_req), 16'd1);
        chk("midreq.addr", bus.mem_addr, 16'h0060);
        r_reset = 1'b0;
        tick();
        chk("midreq.rst_req", 16'(bus.mem_req), 16'd0);
        chk("midreq.rst_addr", bus.mem_addr, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/subsystem_fetch.md
# subsystem_fetch

Instruction-fetch stage sitting directly downstream of the PC adder subsystem. Each fetch samples the current `pc`, issues a read to instruction memory with a req/ready handshake, and latches the returned word and its address. It then pulses `pc_enable` so the PC adder advances. The word is held for the decode stage until acknowledged. A watchdog counter flags a memory that never answers.

## Interface
- `MAX_WAIT`, 255: maximum cycles in REQ without `mem_ready` before a fault is raised. Range 1..255.
- `NOP_INST`, 16'h0000: value driven on `inst` after reset.
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; 0 at a rising edge resets the block.
- `pc`  in  16  current PC from the PC adder subsystem.
- `stall`  in  1  1 = do not start a new fetch.
- `flush`  in  1  1 = abandon the current fetch and drop any held instruction.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  16  read address; stable while `mem_req`=1.
- `mem_ready`  in  1  memory has the data this cycle; sampled only in REQ.
- `mem_rdata`  in  16  read data; valid when `mem_ready`=1.
- `inst`  out  16  latched instruction.
- `inst_pc`  out  16  address `inst` was fetched from.
- `inst_valid`  out  1  `inst` is held for decode.
- `inst_ack`  in  1  decode consumed `inst`; sampled only in HOLD.
- `pc_enable`  out  1  one-cycle pulse to the PC adder to advance the PC.
- `fetch_fault`  out  1  sticky; memory timeout occurred.

## Operation
- States: IDLE, REQ, HOLD, FAULT. All outputs are registered.
- Reset (`reset`=0) has priority over everything:
  - state IDLE;
  - `mem_req`=0, `mem_addr`=0;
  - `inst`=`NOP_INST`, `inst_pc`=0, `inst_valid`=0;
  - `pc_enable`=0, `fetch_fault`=0, wait counter=0.
- `pc_enable` defaults to 0 every cycle unless set below.
- `flush`=1 in IDLE, REQ or HOLD (second priority):
  - state becomes IDLE; `mem_req`=0, `inst_valid`=0, counter=0.
  - No `pc_enable` pulse.
  - Flush overrides a simultaneous `mem_ready` or `inst_ack`.
  - Flush has no effect in FAULT.
- IDLE:
  - If `stall`=0: `mem_addr`<=`pc`, `mem_req`<=1, counter<=0, go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - If `mem_ready`=1: `inst`<=`mem_rdata`, `inst_pc`<=`mem_addr`, `inst_valid`<=1, `mem_req`<=0, `pc_enable`<=1, go to HOLD.
  - Else if counter = `MAX_WAIT`-1: `mem_req`<=0, `fetch_fault`<=1, go to FAULT.
  - Else counter<=counter+1.
  - `stall` is ignored in REQ; an issued fetch completes.
- HOLD:
  - If `inst_ack`=1: `inst_valid`<=0, go to IDLE.
  - Otherwise hold; `inst` and `inst_pc` stay stable.
  - `stall` is ignored in HOLD.
- FAULT: all outputs hold; `fetch_fault`=1 until reset. The only exit is reset.
- Memory contract: memory must ignore a request once `mem_req` falls. A `mem_ready` outside REQ is ignored.
- `inst` and `inst_pc` change only on a successful REQ->HOLD transition or on reset. Flush clears `inst_valid` only.

## Timing
- Edge E0: IDLE samples `pc`; `mem_req`=1 from E0.
- Zero-wait memory (`mem_ready`=1 in the first REQ cycle):
  - at E1, `inst`/`inst_valid`/`pc_enable` are set;
  - at E2, the PC adder registers the new PC and `pc_enable` returns to 0.
- The earliest `inst_ack` is at E2. IDLE is then re-entered and the next fetch samples the updated `pc` at E3.
- With this sequencing a stale `pc` is never sampled. Peak rate is one fetch per 3 cycles.
- Timeout: `MAX_WAIT` REQ cycles without ready puts the block in FAULT. `fetch_fault` is 1 from the edge closing the `MAX_WAIT`th REQ cycle.
- The counter is 8 bits and never wraps: it is cleared on entry to REQ and saturates at the fault.
- Reset in any state takes effect at the next edge. If reset falls mid-REQ, `mem_req` drops that edge.

## Test plan
- Reset, then `pc`=16'h0010 with memory returning 16'hABCD after 2 wait cycles. Required: `mem_addr`=16'h0010 held for 3 cycles, then `inst`=16'hABCD, `inst_pc`=16'h0010, `inst_valid`=1 and a single 1-cycle `pc_enable`.
- Back-to-back fetches with zero-wait memory, `inst_ack` tied 1, PC adder incrementing by 1 from 0. Required: fetched addresses 0,1,2,3 with no repeats, one fetch per 3 cycles.
- `stall`=1 in IDLE for 5 cycles. Required: `mem_req` stays 0; the fetch starts on the edge after `stall` falls.
- `flush`=1 in the same cycle as `mem_ready`=1. Required: IDLE, `inst_valid`=0, no `pc_enable`, `inst` unchanged.
- `MAX_WAIT`=4 and memory never ready. Required: `fetch_fault`=1 after 4 REQ cycles, `mem_req`=0, and the block stays in FAULT despite `flush`. Reset clears `fetch_fault`.
- HOLD with `inst_ack`=0 for 10 cycles, then reset asserted. Required: `inst` stable throughout, then `inst`=`NOP_INST` and `inst_valid`=0 after reset.
